// File: rtl/fetch_decode_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_buffer_pkg
// Description : Shared constants and types for the fetch/decode skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_decode_buffer_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam int          DEFAULT_WIDTH = 32;
    localparam int          DEFAULT_DEPTH = 2;

    // Encoded as {store, unload} so the control bits cast straight onto it
    typedef enum logic [1:0] {
        FDB_IDLE = 2'b00,
        FDB_POP  = 2'b01,
        FDB_PUSH = 2'b10,
        FDB_BOTH = 2'b11
    } fdb_op_e;

endpackage
`default_nettype wire

// File: rtl/fdb_storage.sv
`default_nettype none
// ============================================================================
// Module      : fdb_storage
// Description : DEPTH x (3*WIDTH) register array, one write port, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module fdb_storage
    import fetch_decode_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [3*WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [3*WIDTH-1:0]         rdata
);

    // Contents are intentionally unreset; occupancy lives in the parent
    logic [3*WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_buffer
// Description : FIFO between fetch and decode with flush; optional zero-latency
//               bypass compiled in with FETCH_DECODE_BUFFER_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_inst,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_pc_plus4,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_inst,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_pc_plus4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_store;
    logic               w_unload;
    fdb_op_e            w_op;
    logic [3*WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0]   w_head_inst;
    logic [WIDTH-1:0]   w_head_pc;
    logic [WIDTH-1:0]   w_head_pc_plus4;

    fdb_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (w_store),
        .waddr (r_wr_ptr),
        .wdata ({in_inst, in_pc, in_pc_plus4}),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count < c_depth) | out_ready;
    assign w_push   = in_valid & in_ready & ~flush;
    assign w_pop    = out_valid & out_ready & ~flush;

`ifdef FETCH_DECODE_BUFFER_BYPASS_EN
    logic w_bypass;

    // rst gates the bypass so out_valid drops immediately on reset
    assign w_bypass        = w_empty & in_valid & ~flush & ~rst;
    assign out_valid       = ~w_empty | w_bypass;
    assign w_store         = w_push & ~(w_bypass & out_ready);
    assign w_unload        = w_pop & ~w_empty;
    assign w_head_inst     = w_bypass ? in_inst     : w_rdata[3*WIDTH-1:2*WIDTH];
    assign w_head_pc       = w_bypass ? in_pc       : w_rdata[2*WIDTH-1:WIDTH];
    assign w_head_pc_plus4 = w_bypass ? in_pc_plus4 : w_rdata[WIDTH-1:0];
`else
    assign out_valid       = ~w_empty;
    assign w_store         = w_push;
    assign w_unload        = w_pop;
    assign w_head_inst     = w_rdata[3*WIDTH-1:2*WIDTH];
    assign w_head_pc       = w_rdata[2*WIDTH-1:WIDTH];
    assign w_head_pc_plus4 = w_rdata[WIDTH-1:0];
`endif

    assign out_inst     = out_valid ? w_head_inst     : WIDTH'(NOP_INST);
    assign out_pc       = out_valid ? w_head_pc       : '0;
    assign out_pc_plus4 = out_valid ? w_head_pc_plus4 : '0;
    assign count        = r_count;

    assign w_op = fdb_op_e'({w_store, w_unload});

    // Power-of-two DEPTH lets pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_unload) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case (w_op)
                FDB_PUSH: r_count <= r_count + 1'b1;
                FDB_POP:  r_count <= r_count - 1'b1;
                default:  r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of instruction and PC fields.
REQ-002 SHALL have parameter DEPTH, default 2, number of entries; legal values are powers of two, 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  fetch presents a valid instruction this cycle.
REQ-006 SHALL have port in_ready  output  1  buffer accepts the presented instruction this cycle.
REQ-007 SHALL have port in_inst  input  WIDTH  fetched instruction word.
REQ-008 SHALL have port in_pc  input  WIDTH  PC of the fetched instruction.
REQ-009 SHALL have port in_pc_plus4  input  WIDTH  PC+4 of the fetched instruction.
REQ-010 SHALL have port flush  input  1  taken branch redirect (branch & zero); discard all contents.
REQ-011 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-012 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-013 SHALL have ports out_inst, out_pc, out_pc_plus4  output  WIDTH each  head entry fields.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push occurs iff in_valid & in_ready & !flush; pop occurs iff out_valid & out_ready & !flush.
REQ-016 in_ready SHALL be (count < DEPTH) | out_ready, i.e. a full buffer accepts when the head is popped in the same cycle.
REQ-017 out_valid SHALL be (count != 0).
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-019 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 Latency without bypass: an instruction pushed in cycle N is visible at out_* in cycle N+1.
REQ-021 flush SHALL have priority: on its edge, count, both pointers and out_valid go to 0; in_* that cycle is dropped; no pop is signalled.
REQ-022 When out_valid is 0, out_inst SHALL drive the NOP constant (32'h00000013) and out_pc/out_pc_plus4 SHALL drive 0.
REQ-023 Head data SHALL remain stable while out_valid & !out_ready.

Reset
REQ-024 rst asserted SHALL immediately clear count, pointers, out_valid to 0 and out_inst to NOP, regardless of clk, including mid-transfer.
REQ-025 First push SHALL be accepted on the first rising edge after rst deasserts.
REQ-026 Storage array contents need no reset; only occupancy is reset.

Configuration
REQ-027 Macro FETCH_DECODE_BUFFER_BYPASS_EN SHALL compile in a zero-latency path: when count==0 and in_valid & !flush, out_valid=1 and out_* = in_* combinationally; if out_ready also 1, nothing is stored.
REQ-028 Without FETCH_DECODE_BUFFER_BYPASS_EN, REQ-020 latency applies and no combinational path exists from in_* to out_*.

Structure
REQ-029 Shared package SHALL hold NOP_INST (32'h00000013) and the default WIDTH/DEPTH constants.
REQ-030 Storage SHALL be one sub-module fdb_storage: DEPTH x (3*WIDTH) register array, one write port, one async read port.
REQ-031 Pointer/count control SHALL live in fetch_decode_buffer.

Verification
REQ-032 Reset then push inst 32'h00500093 pc 0 with out_ready=0 -> next cycle out_valid=1, out_inst=32'h00500093, out_pc_plus4=4, count=1.
REQ-033 Push 3 instructions (pc 0,4,8), out_ready=0, DEPTH=2 -> in_ready=0 after two, count=2, third held by fetch; raising out_ready pops pc 0 then 4 then accepts 8.
REQ-034 Full buffer, in_valid=1 and out_ready=1 same cycle -> count stays 2, pop pc 0, push pc 8, order 4,8 preserved.
REQ-035 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_inst=32'h00000013, pushed instruction lost.
REQ-036 Push/pop 10 instructions continuously -> pointers wrap, output order equals input order, no loss or duplicate.
REQ-037 Assert rst asynchronously mid-cycle with count=1 -> out_valid falls before next clk edge; with FETCH_DECODE_BUFFER_BYPASS_EN, empty buffer plus in_valid shows in_inst on out_inst same cycle.
